// File: rtl/data_sync_mc.sv
// rtl/data_sync_mc.sv - multi-channel enable-qualified bus synchroniser with valid/ready and toggle ack
// Optional overrun tracking is built only when DSYNC_OVERRUN_EN is defined.
module data_sync_mc #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 2,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH-1:0]           sync_ready,
    input  logic [NUM_CH-1:0]           overrun_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0] Sync_bus,
    output logic [NUM_CH-1:0]           sync_valid,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           ack_toggle,
    output logic [NUM_CH-1:0]           overrun
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [NUM_STAGES-1:0] r_sync;
        logic                  r_prev;
        logic [BUS_WIDTH-1:0]  r_data;
        logic                  r_valid;
        logic                  r_pulse;
        logic                  r_ack;
        logic                  w_sync_last;
        logic                  w_evt;

        assign w_sync_last = r_sync[NUM_STAGES-1];

        if (TOGGLE_MODE != 0) begin : g_toggle
            assign w_evt = w_sync_last ^ r_prev;
        end else begin : g_edge
            assign w_evt = w_sync_last & ~r_prev;
        end

        // An event always reloads the word, so a simultaneous accept keeps valid high
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_sync  <= '0;
                r_prev  <= 1'b0;
                r_data  <= '0;
                r_valid <= 1'b0;
                r_pulse <= 1'b0;
                r_ack   <= 1'b0;
            end else begin
                r_sync  <= {r_sync[NUM_STAGES-2:0], bus_enable[g]};
                r_prev  <= w_sync_last;
                r_pulse <= w_evt;
                if (w_evt) begin
                    r_data  <= Unsync_bus[g*BUS_WIDTH +: BUS_WIDTH];
                    r_valid <= 1'b1;
                    r_ack   <= ~r_ack;
                end else if (r_valid && sync_ready[g]) begin
                    r_valid <= 1'b0;
                end
            end
        end

`ifdef DSYNC_OVERRUN_EN
        logic r_ovr;

        // A new overrun outranks a clear arriving in the same cycle
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_ovr <= 1'b0;
            end else if (w_evt && r_valid && !sync_ready[g]) begin
                r_ovr <= 1'b1;
            end else if (overrun_clr[g]) begin
                r_ovr <= 1'b0;
            end
        end

        assign overrun[g] = r_ovr;
`else
        assign overrun[g] = 1'b0;
`endif

        assign Sync_bus[g*BUS_WIDTH +: BUS_WIDTH] = r_data;
        assign sync_valid[g]   = r_valid;
        assign enable_pulse[g] = r_pulse;
        assign ack_toggle[g]   = r_ack;
    end

`ifndef DSYNC_OVERRUN_EN
    logic w_unused_clr;
    assign w_unused_clr = ^overrun_clr;
`endif

endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
Parametrised multi-channel successor to the team's single-bus enable-qualified synchroniser. It sits in the destination clock domain and takes NUM_CH independent buses, each qualified by its own bus_enable line from a foreign domain. Each enable passes through an NUM_STAGES flop chain, and the block detects a new-word event. On an event it captures the bus and presents it downstream with a valid/ready handshake, plus a toggle acknowledge for the source side. It adds a selectable edge/toggle signalling mode and overrun detection.

Parameters:
NUM_STAGES, 2, synchroniser depth per enable line (>=2)
BUS_WIDTH, 8, data width per channel
NUM_CH, 2, number of independent channels (>=1)
TOGGLE_MODE, 0, 0 = event on rising edge of synchronised enable; 1 = event on any transition

Ports:
CLK  input  1  destination-domain clock
RST  input  1  asynchronous active-low reset
Unsync_bus  input  NUM_CH*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; stable while its enable is synchronised
bus_enable  input  NUM_CH  per-channel asynchronous qualifier
sync_ready  input  NUM_CH  downstream accepts channel word
overrun_clr  input  NUM_CH  clears sticky overrun flag
Sync_bus  output  NUM_CH*BUS_WIDTH  captured data, same slicing as Unsync_bus
sync_valid  output  NUM_CH  captured word pending
enable_pulse  output  NUM_CH  one-cycle pulse per detected event
ack_toggle  output  NUM_CH  flips once per captured word; source synchronises it
overrun  output  NUM_CH  sticky: event arrived while previous word unaccepted

Behaviour:
- Reset (RST low, async) clears all sync flops, edge flops, Sync_bus, sync_valid, enable_pulse, ack_toggle and overrun to 0.
- Per channel c, the flop chain sync[0..NUM_STAGES-1] is fed by bus_enable[c]. prev = sync[NUM_STAGES-1] delayed by one cycle.
- evt (combinational): TOGGLE_MODE=0: sync_last & ~prev. TOGGLE_MODE=1: sync_last ^ prev.
- Latency: if bus_enable changes before edge 1, evt is high between edges NUM_STAGES and NUM_STAGES+1. Outputs update at edge NUM_STAGES+1. This matches the legacy block at NUM_STAGES=2 (pulse after edge 3).
- On evt, at the next edge: Sync_bus slice <= Unsync_bus slice, enable_pulse=1 for exactly one cycle, sync_valid<=1, ack_toggle<=~ack_toggle.
- Without evt, Sync_bus holds and enable_pulse=0.
- Handshake: sync_valid & sync_ready at an edge with no evt clears sync_valid. Sync_bus holds its value after acceptance.
- Simultaneous evt and accept (valid&ready): the new word loads and sync_valid stays 1. No overrun.
- evt while sync_valid=1 and sync_ready=0: latest wins. Sync_bus is overwritten, sync_valid stays 1, and overrun is set.
- overrun_clr clears overrun at the next edge. A same-cycle overrun set has priority over clear.
- sync_ready while sync_valid=0 is ignored.
- Channels are fully independent; no cross-channel ordering is guaranteed.
- Reset mid-transfer discards pending words. After release, an enable already high is seen as a rising edge (TOGGLE_MODE=0) once propagated. In TOGGLE_MODE=1, the source must also reset its toggle.
- TOGGLE_MODE=1 has no width restriction on enable pulses. TOGGLE_MODE=0 requires enable high and low each for at least NUM_STAGES+1 destination cycles.

Optional Feature:
DSYNC_OVERRUN_EN. When defined, the overrun logic is implemented as described above. When undefined, overrun outputs are constant 0, overrun_clr is unused, and no overrun flops are synthesised. The latest-wins overwrite behaviour is unchanged.

Test Plan:
1. NUM_STAGES=2, TOGGLE_MODE=0: set ch0 Unsync=8'hA5, raise bus_enable[0] -> enable_pulse[0] high for one cycle after edge 3, Sync_bus[7:0]=A5, sync_valid[0]=1, ack_toggle[0]=1. Hold enable high 10 cycles -> no further pulse.
2. Handshake: with valid pending, hold sync_ready[0]=0 for 5 cycles -> valid held. Assert ready for 1 cycle -> valid 0, Sync_bus still A5.
3. Overrun: word 8'h11 pending, ready=0, send second event with 8'h22 -> Sync_bus=22, valid=1, overrun[0]=1. Pulse overrun_clr -> overrun 0. With the macro undefined -> overrun stays 0.
4. TOGGLE_MODE=1: toggle bus_enable[1] three times, 8 cycles apart, data 01/02/03 with ready=1 -> three enable_pulse[1], ack_toggle[1] ends at 1, last Sync_bus slice = 03.
5. Simultaneous: ch0 and ch1 events on the same cycle with evt coinciding with ch0 accept -> both capture, ch0 valid stays 1, no overrun.
6. Assert RST low mid-chain (one cycle after enable rise) -> all outputs 0 immediately. Release with enable still high -> one event, pulse NUM_STAGES+1 edges after release.
